instruction_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the KGP-RISC core, sitting directly upstream of the branching mechanism. It owns the architectural PC and fetches the word at that PC from instruction memory using a request/grant/response handshake. It holds the fetched instruction for decode, and on instruction retirement loads the next PC computed by the branching stage. Its `pc` output drives the branching stage's `pc_in`, and the branching stage's `pc_out` returns as `next_pc`.

---
 rtl/kgp_risc_pkg.sv | 16 +
 rtl/ifu_wait_timer.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: fetch FSM state encoding, default datapath widths
// and the architectural reset PC.
package kgp_risc_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INSTR_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'd0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_wait_timer.sv
// Loadable up-counter with a terminal-count flag, used as the fetch response watchdog.
// Only present when IFU_FETCH_TIMEOUT_EN is defined.
`ifdef IFU_FETCH_TIMEOUT_EN
module ifu_wait_timer #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TC_VAL = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Flags the cycle whose increment makes the count reach TC_VAL.
    assign o_tc = i_en && (r_cnt == CNT_W'(TC_VAL - 1));

    // Wait counter: cleared on load, counts every enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/instruction_fetch_unit.sv
// KGP-RISC PC and instruction-fetch stage (req/gnt/rvalid fetch, hold-for-decode).
// Optional response watchdog enabled by IFU_FETCH_TIMEOUT_EN.
module instruction_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       INSTR_W     = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic               fetch_err
);

    ifu_state_t          r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_id_valid;
    logic [INSTR_W-1:0]  r_id_instr;
    logic                w_imem_req;
    logic                w_tmr_tc;

    // Request is suppressed while reset is held so nothing is issued in the reset cycle.
    assign w_imem_req = rst && (r_state == S_REQ) && !halt;

`ifdef IFU_FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic r_fetch_err;
    logic w_tmr_load;
    logic w_tmr_en;

    assign w_tmr_load = w_imem_req && imem_gnt;
    assign w_tmr_en   = (r_state == S_WAIT) && !imem_rvalid;

    ifu_wait_timer #(
        .CNT_W  (CNT_W),
        .TC_VAL (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_en   (w_tmr_en),
        .o_tc   (w_tmr_tc)
    );

    assign fetch_err = r_fetch_err;
`else
    assign w_tmr_tc  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Fetch FSM with registered PC, instruction holding register and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= {INSTR_W{1'b0}};
`ifdef IFU_FETCH_TIMEOUT_EN
            r_fetch_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    r_id_valid <= 1'b0;
                    if (w_imem_req && imem_gnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_id_instr <= imem_rdata;
                        r_id_valid <= 1'b1;
                        r_state    <= S_HOLD;
                    end else if (w_tmr_tc) begin
`ifdef IFU_FETCH_TIMEOUT_EN
                        r_fetch_err <= 1'b1;
`endif
                        r_state <= S_ERR;
                    end
                end
                S_HOLD: begin
                    // next_pc only matters on the retire handshake edge.
                    if (id_ready) begin
                        r_pc       <= next_pc;
                        r_id_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end
`ifdef IFU_FETCH_TIMEOUT_EN
                S_ERR: begin
                    r_id_valid  <= 1'b0;
                    r_fetch_err <= 1'b1;
                end
`endif
                default: begin
                    r_id_valid <= 1'b0;
                    r_state    <= S_REQ;
                end
            endcase
        end
    end

    assign imem_req  = w_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit, plus hand-written
// watchdog / long-wait sequence (behaviour depends on IFU_FETCH_TIMEOUT_EN).
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        fetch_err;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        rst, halt, gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic        e_fe;
    } vec_t;

    vec_t tbl[$];

    instruction_fetch_unit #(
        .ADDR_W      (32),
        .INSTR_W     (32),
        .RESET_PC    (32'd0),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .pc          (pc),
        .next_pc     (next_pc),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void v(input logic r, input logic h, input logic g, input logic rv,
                              input logic [31:0] rd, input logic rdy, input logic [31:0] npc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_instr);
        vec_t t;
        t = '{r, h, g, rv, rd, rdy, npc, e_req, e_addr, e_vld, e_instr, 1'b0};
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and check outputs before the next rising edge.
    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst         = t.rst;
        halt        = t.halt;
        imem_gnt    = t.gnt;
        imem_rvalid = t.rv;
        imem_rdata  = t.rdata;
        id_ready    = t.rdy;
        next_pc     = t.npc;
        #1;
        n_vec++;
        chk("imem_req",  idx, {31'd0, imem_req},  {31'd0, t.e_req});
        chk("imem_addr", idx, imem_addr,          t.e_addr);
        chk("pc",        idx, pc,                 t.e_addr);
        chk("id_valid",  idx, {31'd0, id_valid},  {31'd0, t.e_vld});
        chk("id_instr",  idx, id_instr,           t.e_instr);
        chk("fetch_err", idx, {31'd0, fetch_err}, {31'd0, t.e_fe});
    endtask

    task automatic hand(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                        input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                        input logic [31:0] e_instr, input logic e_fe, input int idx);
        vec_t t;
        t = '{r, 1'b0, g, rv, rd, 1'b0, 32'd0, e_req, e_addr, e_vld, e_instr, e_fe};
        apply(t, idx);
    endtask

    initial begin
        logic to_en;
`ifdef IFU_FETCH_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        rst = 1'b0; halt = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = 32'd0; id_ready = 1'b0; next_pc = 32'd0;

        //  rst halt gnt rv rdata          rdy npc            req addr           vld instr
        // reset, then first fetch
        v(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
        v(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0);
        v(1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0);
        v(1, 0, 0, 1, 32'hA5A5_0001,  0, 32'h0,          0, 32'h0,          0, 32'h0);
        v(1, 0, 0, 0, 32'h0,          1, 32'h1,          0, 32'h0,          1, 32'hA5A5_0001);
        // back-to-back sequential fetches
        v(1, 0, 1, 0, 32'h0,          1, 32'h0,          1, 32'h1,          0, 32'hA5A5_0001);
        v(1, 0, 0, 1, 32'h2,          1, 32'h0,          0, 32'h1,          0, 32'hA5A5_0001);
        v(1, 0, 0, 0, 32'h0,          1, 32'h2,          0, 32'h1,          1, 32'h2);
        v(1, 0, 1, 0, 32'h0,          1, 32'h0,          1, 32'h2,          0, 32'h2);
        v(1, 0, 0, 1, 32'h3,          1, 32'h0,          0, 32'h2,          0, 32'h2);
        v(1, 0, 0, 0, 32'h0,          1, 32'h3,          0, 32'h2,          1, 32'h3);
        v(1, 0, 1, 0, 32'h0,          1, 32'h0,          1, 32'h3,          0, 32'h3);
        // decode stall with changing next_pc, branch to 0x40
        v(1, 0, 0, 1, 32'hB0B0_0004,  0, 32'h0,          0, 32'h3,          0, 32'h3);
        v(1, 0, 0, 0, 32'h0,          0, 32'h10,         0, 32'h3,          1, 32'hB0B0_0004);
        v(1, 0, 0, 0, 32'h0,          0, 32'h20,         0, 32'h3,          1, 32'hB0B0_0004);
        v(1, 0, 0, 1, 32'hDEAD_0000,  0, 32'h30,         0, 32'h3,          1, 32'hB0B0_0004);
        v(1, 0, 0, 0, 32'h0,          0, 32'h35,         0, 32'h3,          1, 32'hB0B0_0004);
        v(1, 0, 0, 0, 32'h0,          1, 32'h40,         0, 32'h3,          1, 32'hB0B0_0004);
        // grant latency, then halt in S_REQ for 5 cycles
        v(1, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h40,         0, 32'hB0B0_0004);
        for (int i = 0; i < 5; i++)
            v(1, 1, 1, 0, 32'h0,      0, 32'h0,          0, 32'h40,         0, 32'hB0B0_0004);
        // halt during S_WAIT does not abort the fetch
        v(1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h40,         0, 32'hB0B0_0004);
        v(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h40,         0, 32'hB0B0_0004);
        v(1, 1, 0, 1, 32'hC0DE_0005,  0, 32'h0,          0, 32'h40,         0, 32'hB0B0_0004);
        v(1, 1, 0, 0, 32'h0,          1, 32'h41,         0, 32'h40,         1, 32'hC0DE_0005);
        v(1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h41,         0, 32'hC0DE_0005);
        // reset in S_WAIT, stale response after release
        v(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h41,         0, 32'hC0DE_0005);
        v(1, 0, 0, 1, 32'hDEAD_BEEF,  0, 32'h0,          1, 32'h0,          0, 32'h0);
        v(1, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0);
        // PC wrap-around from all-ones
        v(1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0);
        v(1, 0, 0, 1, 32'h6,          0, 32'h0,          0, 32'h0,          0, 32'h0);
        v(1, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFF,  0, 32'h0,          1, 32'h6);
        v(1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFF,  0, 32'h6);
        v(1, 0, 0, 1, 32'h7,          0, 32'h0,          0, 32'hFFFF_FFFF,  0, 32'h6);
        v(1, 0, 0, 0, 32'h0,          1, 32'h0,          0, 32'hFFFF_FFFF,  1, 32'h7);
        v(1, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h7);

        foreach (tbl[i]) apply(tbl[i], i);

        // Long response wait: watchdog fires after 4 S_WAIT cycles when enabled.
        hand(1, 1, 0, 32'h0,       1, 32'h0, 0, 32'h7, 0,     100);
        for (int k = 0; k < 4; k++)
            hand(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h7, 0,     101 + k);
        hand(1, 0, 0, 32'h0,       0, 32'h0, 0, 32'h7, to_en, 105);
        hand(1, 0, 1, 32'h1111,    0, 32'h0, 0, 32'h7, to_en, 106);
        if (to_en)
            hand(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h7,    1,  107);
        else
            hand(1, 0, 0, 32'h0,   0, 32'h0, 1, 32'h1111, 0,  107);
        hand(1, 0, 0, 32'h0,       0, 32'h0, !to_en, to_en ? 32'h7 : 32'h1111, to_en, 108);
        // reset clears the sticky error
        hand(0, 0, 0, 32'h0,       0, 32'h0, !to_en, to_en ? 32'h7 : 32'h1111, to_en, 109);
        hand(1, 0, 0, 32'h0,       1, 32'h0, 0, 32'h0, 0,     110);
        hand(1, 0, 0, 32'h0,       1, 32'h0, 0, 32'h0, 0,     111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
